imem_loader: RTL

IMEM_LOADER -- requirements
Module: imem_loader

---
 rtl/mips_pkg.sv | 26 ++
 rtl/word_packer.sv | 35 +++
 rtl/imem_loader.sv | 137 +++++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// Shared loader types and constants: FSM state encoding, header width and word geometry.
package mips_pkg;

    // Width of the big-endian word-count header.
    localparam int unsigned HDR_WIDTH      = 16;
    // Bytes assembled into each instruction word.
    localparam int unsigned BYTES_PER_WORD = 4;
    // Width of the per-word byte counter.
    localparam int unsigned BYTE_CNT_WIDTH = $clog2(BYTES_PER_WORD);

    typedef enum logic [2:0] {
        StIdle,
        StLenHi,
        StLenLo,
        StData,
        StDone,
        StErr
    } loadState_t;

    // Byte address of word idx; 32-bit arithmetic that wraps naturally.
    function automatic logic [31:0] wordAddr(input logic [31:0] base,
                                             input logic [HDR_WIDTH-1:0] idx);
        return base + {{(32 - HDR_WIDTH - 2){1'b0}}, idx, 2'b00};
    endfunction

endpackage

// File: rtl/word_packer.sv
// Assembles accepted bytes MSB-first into a word and flags the cycle the last byte arrives.
module word_packer
    import mips_pkg::*;
(
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        clear,
    input  logic                        accept,
    input  logic [7:0]                  inByte,
    output logic [8*BYTES_PER_WORD-1:0] nextWord,
    output logic                        wordComplete
);

    // Only the first BYTES_PER_WORD-1 bytes need storing; the last one is taken live.
    logic [8*(BYTES_PER_WORD-1)-1:0] shiftQ;
    logic [BYTE_CNT_WIDTH-1:0]       byteCntQ;

    assign nextWord     = {shiftQ, inByte};
    assign wordComplete = accept && (byteCntQ == BYTE_CNT_WIDTH'(BYTES_PER_WORD - 1));

    // Shift in one byte per accept; clear discards any partial word.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            shiftQ   <= '0;
            byteCntQ <= '0;
        end else if (clear) begin
            shiftQ   <= '0;
            byteCntQ <= '0;
        end else if (accept) begin
            shiftQ   <= nextWord[8*(BYTES_PER_WORD-1)-1:0];
            byteCntQ <= wordComplete ? '0 : byteCntQ + BYTE_CNT_WIDTH'(1);
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Loads a length-prefixed byte stream into instruction memory, then releases the CPU.
module imem_loader
    import mips_pkg::*;
#(
    parameter int unsigned MAX_WORDS = 256,
    parameter logic [31:0] BASE_ADDR = 32'h0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    output logic        wr_en,
    output logic [31:0] wr_addr,
    output logic [31:0] wr_data,
    output logic        cpu_run,
    output logic        done,
    output logic        error
);

    loadState_t stateQ, stateD;

    logic [7:0]           lenHiQ, lenHiD;
    logic [HDR_WIDTH-1:0] lenQ, lenD;
    logic [HDR_WIDTH-1:0] wordCntQ, wordCntD;
    logic                 wrEnQ, wrEnD;
    logic [31:0]          wrAddrQ, wrAddrD;
    logic [31:0]          wrDataQ, wrDataD;

    logic                 accept;
    logic                 packerClear;
    logic                 packerAccept;
    logic [31:0]          packedWord;
    logic                 wordComplete;
    logic [HDR_WIDTH-1:0] headerLen;

    // Status outputs decode straight from state so an async reset clears them at once.
    assign in_ready = (stateQ == StLenHi) || (stateQ == StLenLo) || (stateQ == StData);
    assign cpu_run  = (stateQ == StDone);
    assign done     = (stateQ == StDone);
    assign error    = (stateQ == StErr);
    assign wr_en    = wrEnQ;
    assign wr_addr  = wrAddrQ;
    assign wr_data  = wrDataQ;

    // A start in the same cycle swallows the byte.
    assign accept       = in_valid && in_ready && !start;
    assign packerAccept = accept && (stateQ == StData);
    assign headerLen    = {lenHiQ, in_data};

    word_packer u_packer (
        .clk          (clk),
        .reset        (reset),
        .clear        (packerClear),
        .accept       (packerAccept),
        .inByte       (in_data),
        .nextWord     (packedWord),
        .wordComplete (wordComplete)
    );

    // Next-state, counters and registered write-port values.
    always_comb begin
        stateD      = stateQ;
        lenHiD      = lenHiQ;
        lenD        = lenQ;
        wordCntD    = wordCntQ;
        wrEnD       = 1'b0;
        wrAddrD     = '0;
        wrDataD     = '0;
        packerClear = 1'b0;

        if (start) begin
            stateD      = StLenHi;
            lenHiD      = '0;
            lenD        = '0;
            wordCntD    = '0;
            packerClear = 1'b1;
        end else begin
            unique case (stateQ)
                StLenHi: begin
                    if (accept) begin
                        lenHiD = in_data;
                        stateD = StLenLo;
                    end
                end
                StLenLo: begin
                    if (accept) begin
                        lenD = headerLen;
                        if (headerLen == '0) begin
                            stateD = StDone;
                        end else if (32'(headerLen) > MAX_WORDS) begin
                            stateD = StErr;
                        end else begin
                            stateD = StData;
                        end
                    end
                end
                StData: begin
                    if (wordComplete) begin
                        wrEnD    = 1'b1;
                        wrAddrD  = wordAddr(BASE_ADDR, wordCntQ);
                        wrDataD  = packedWord;
                        wordCntD = wordCntQ + HDR_WIDTH'(1);
                        // DONE lands on the same edge as the final word's strobe.
                        if (wordCntQ == lenQ - HDR_WIDTH'(1)) begin
                            stateD = StDone;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // State and write-port registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stateQ   <= StIdle;
            lenHiQ   <= '0;
            lenQ     <= '0;
            wordCntQ <= '0;
            wrEnQ    <= 1'b0;
            wrAddrQ  <= '0;
            wrDataQ  <= '0;
        end else begin
            stateQ   <= stateD;
            lenHiQ   <= lenHiD;
            lenQ     <= lenD;
            wordCntQ <= wordCntD;
            wrEnQ    <= wrEnD;
            wrAddrQ  <= wrAddrD;
            wrDataQ  <= wrDataD;
        end
    end

endmodule
